// File: rtl/program_launcher.sv
// rtl/program_launcher.sv - button synchroniser, debouncer and one-shot program selector launcher
module program_launcher #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        btn_fib,
    input  logic        btn_sort,
    input  logic        btn_save,
    input  logic        btn_load,
    output logic [31:0] program_selector,
    output logic        launch,
    output logic        busy
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_HOLD         = 2'd1;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;

    // Bit order matches priority: bit 0 (fib) is the highest.
    logic [3:0] raw;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] db;
    logic [3:0] db_d;
    logic [3:0] rise;
    logic [DW-1:0] db_cnt [4];

    logic [1:0]    state;
    logic [HW-1:0] hold_cnt;
    logic [2:0]    sel_q;
    logic          launch_q;
    logic [2:0]    rise_code;

    assign raw = {btn_load, btn_save, btn_sort, btn_fib};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 4'b0;
            sync2 <= 4'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_debounce
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                db_cnt[i] <= '0;
                db[i]     <= 1'b0;
            end else if (sync2[i] == db[i]) begin
                db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
                db[i]     <= sync2[i];
                db_cnt[i] <= '0;
            end else begin
                db_cnt[i] <= db_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db_d <= 4'b0;
        end else begin
            db_d <= db;
        end
    end

    assign rise = db & ~db_d;

    always_comb begin
        rise_code = 3'd0;
        if (rise[0]) begin
            rise_code = 3'd1;
        end else if (rise[1]) begin
            rise_code = 3'd2;
        end else if (rise[2]) begin
            rise_code = 3'd3;
        end else if (rise[3]) begin
            rise_code = 3'd4;
        end
    end

    // Rises outside IDLE are dropped, so a launch needs a full debounced release first.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            sel_q    <= 3'd0;
            launch_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise != 4'b0) begin
                        state    <= ST_HOLD;
                        sel_q    <= rise_code;
                        hold_cnt <= HOLD_LAST;
                        launch_q <= 1'b1;
                    end else begin
                        sel_q    <= 3'd0;
                        launch_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    launch_q <= 1'b0;
                    if (hold_cnt == '0) begin
                        state <= ST_WAIT_RELEASE;
                        sel_q <= 3'd0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                ST_WAIT_RELEASE: begin
                    sel_q    <= 3'd0;
                    launch_q <= 1'b0;
                    if (db == 4'b0) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    sel_q    <= 3'd0;
                    launch_q <= 1'b0;
                end
            endcase
        end
    end

    assign program_selector = {29'b0, sel_q};
    assign launch           = launch_q;
    assign busy             = (state == ST_HOLD) || (state == ST_WAIT_RELEASE);

endmodule
